pwm_dac: RTL

PWM_DAC -- requirements
Module: pwm_dac

---
 rtl/pwm_dac_pkg.sv | 14 +
 rtl/pwm_dac_prescaler.sv | 29 ++
 rtl/pwm_dac.sv | 106 ++++++++++
 3 files changed

// File: rtl/pwm_dac_pkg.sv
// PWM DAC shared types and constants.
// Optional overrun counter is enabled with PWM_DAC_OVF_CNT_EN.
package pwm_dac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int OVF_W     = 8;

endpackage

// File: rtl/pwm_dac_prescaler.sv
// PWM DAC prescaler: one tick every DIV clocks.
// Clear holds the divider at zero and suppresses the tick.
module pwm_dac_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt;

  assign tick = !clear && (pcnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
    end else if (clear || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_dac.sv
// PWM DAC: buffered duty samples, period-aligned updates.
// Define PWM_DAC_OVF_CNT_EN to add the saturating overrun_cnt port.
module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pwm_out,
  output logic             period_done
`ifdef PWM_DAC_OVF_CNT_EN
  ,
  output logic [OVF_W-1:0] overrun_cnt
`endif
);

  localparam logic [WIDTH-1:0] CMAX = '1;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] active_duty;
  logic [WIDTH-1:0] pending;
  logic             pending_full;
  logic             idle;
  logic             tick;
  logic             boundary;
  logic             accept;
  logic             load;

  assign idle         = (state == IDLE);
  assign sample_ready = !pending_full;
  assign accept       = sample_valid && !pending_full;
  assign boundary     = tick && (cnt == CMAX);
  assign load         = pending_full &&
                        ((idle && enable) || boundary);

  pwm_dac_prescaler #(
    .DIV (DIV)
  ) u_pre (
    .clk   (clk),
    .rst   (rst),
    .clear (idle),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      active_duty  <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      pwm_out      <= 1'b0;
      period_done  <= 1'b0;
    end else begin
      period_done <= boundary;
      if (load) begin
        active_duty <= pending;
      end
      // accept and load never coincide: accept needs an empty buffer
      if (accept) begin
        pending      <= sample_in;
        pending_full <= 1'b1;
      end else if (load) begin
        pending_full <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          cnt     <= '0;
          pwm_out <= 1'b0;
          if (enable) state <= RUN;
        end
        RUN: begin
          pwm_out <= (cnt < active_duty);
          if (tick) cnt <= cnt + 1'b1;
          if (!enable) state <= DRAIN;
        end
        DRAIN: begin
          pwm_out <= (cnt < active_duty);
          if (tick) cnt <= cnt + 1'b1;
          if (enable) state <= RUN;
          else if (boundary) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PWM_DAC_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_cnt <= '0;
    end else if (sample_valid && pending_full &&
                 (overrun_cnt != '1)) begin
      overrun_cnt <= overrun_cnt + 1'b1;
    end
  end
`endif

endmodule
